// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings and helpers for the dmem_ctrl data-memory sequencer.
// Holds access-size codes, FSM states, lane merging and the legality check.
package dmem_ctrl_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RMW_WR = 2'd2;
    localparam logic [1:0] ST_ERR    = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ACCESS = ST_ACCESS,
        RMW_WR = ST_RMW_WR,
        ERR    = ST_ERR
    } state_e;

    // Splices right-aligned store data into the lanes selected by size and lane.
    function automatic logic [31:0] merge_lane(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [1:0]  size,
        input logic [1:0]  lane
    );
        logic [31:0] w;
        w = old_word;
        case (size)
            SZ_B:    w[{lane, 3'b000} +: 8]        = wdata[7:0];
            SZ_H:    w[{lane[1], 4'b0000} +: 16]   = wdata[15:0];
            default: w                             = wdata;
        endcase
        return w;
    endfunction

    function automatic logic is_legal(
        input logic [1:0]  size,
        input logic [31:0] addr,
        input int unsigned depth
    );
        logic aligned;
        case (size)
            SZ_B:    aligned = 1'b1;
            SZ_H:    aligned = ~addr[0];
            SZ_W:    aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        return aligned && ({2'b00, addr[31:2]} < depth);
    endfunction

endpackage

// File: rtl/dmem_ctrl_rr_arb.sv
// Two-input round-robin arbiter; index 0 is port C, index 1 is port D.
// After each grant, priority passes to the port that did not win.
module dmem_ctrl_rr_arb #(
    parameter int C_FIRST = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // ptr_q names the port that wins the next contended cycle
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr_q ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = gnt[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= (C_FIRST == 0);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Shares a single-ported word memory between a core port (C) and a loader port (D),
// turning sub-word stores into read-modify-write sequences and rejecting bad accesses.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH   = 64,
    parameter int          C_FIRST = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [1:0]  c_size,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_gnt,
    output logic        c_done,
    output logic        c_err,
    output logic [31:0] c_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_done,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] wbuf_q, wbuf_d;
    logic        c_done_q, c_done_d, d_done_q, d_done_d;
    logic        c_err_q, c_err_d, d_err_q, d_err_d;
    logic [31:0] c_rdata_q, c_rdata_d, d_rdata_q, d_rdata_d;

    logic [1:0]  arb_req, arb_gnt;
    logic        sel_we;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr, sel_wdata;

    // Requests are only considered while idle, and never while reset is held.
    assign arb_req = ((state_q == IDLE) && !reset) ? {d_req, c_req} : 2'b00;

    dmem_ctrl_rr_arb #(.C_FIRST(C_FIRST)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (arb_req),
        .advance (|arb_req),
        .gnt     (arb_gnt)
    );

    assign c_gnt = arb_gnt[0];
    assign d_gnt = arb_gnt[1];

    always_comb begin
        if (arb_gnt[1]) begin
            sel_we    = d_we;
            sel_size  = d_size;
            sel_addr  = d_addr;
            sel_wdata = d_wdata;
        end else begin
            sel_we    = c_we;
            sel_size  = c_size;
            sel_addr  = c_addr;
            sel_wdata = c_wdata;
        end
    end

    assign mem_a   = {addr_q[31:2], 2'b00};
    assign c_done  = c_done_q;
    assign d_done  = d_done_q;
    assign c_err   = c_err_q;
    assign d_err   = d_err_q;
    assign c_rdata = c_rdata_q;
    assign d_rdata = d_rdata_q;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wbuf_d    = wbuf_q;
        c_rdata_d = c_rdata_q;
        d_rdata_d = d_rdata_q;
        c_done_d  = 1'b0;
        d_done_d  = 1'b0;
        c_err_d   = 1'b0;
        d_err_d   = 1'b0;
        mem_we    = 1'b0;
        mem_wd    = 32'h0;
        case (state_q)
            IDLE: begin
                if (|arb_gnt) begin
                    owner_d = arb_gnt[1];
                    we_d    = sel_we;
                    size_d  = sel_size;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    state_d = is_legal(sel_size, sel_addr, DEPTH) ? ACCESS : ERR;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    if (owner_q) d_rdata_d = mem_rd;
                    else         c_rdata_d = mem_rd;
                    c_done_d = ~owner_q;
                    d_done_d = owner_q;
                    state_d  = IDLE;
                end else if (size_q == SZ_W) begin
                    mem_we   = 1'b1;
                    mem_wd   = wdata_q;
                    c_done_d = ~owner_q;
                    d_done_d = owner_q;
                    state_d  = IDLE;
                end else begin
                    // Read phase of a sub-word store: merge now, write next cycle
                    wbuf_d  = merge_lane(mem_rd, wdata_q, size_q, addr_q[1:0]);
                    state_d = RMW_WR;
                end
            end
            RMW_WR: begin
                mem_we   = 1'b1;
                mem_wd   = wbuf_q;
                c_done_d = ~owner_q;
                d_done_d = owner_q;
                state_d  = IDLE;
            end
            ERR: begin
                c_done_d = ~owner_q;
                d_done_d = owner_q;
                c_err_d  = ~owner_q;
                d_err_d  = owner_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            wbuf_q    <= 32'h0;
            c_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            c_err_q   <= 1'b0;
            d_err_q   <= 1'b0;
            c_rdata_q <= 32'h0;
            d_rdata_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wbuf_q    <= wbuf_d;
            c_done_q  <= c_done_d;
            d_done_q  <= d_done_d;
            c_err_q   <= c_err_d;
            d_err_q   <= d_err_d;
            c_rdata_q <= c_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: a behavioural word memory sits on the mem_* side,
// expectations are queued per port when requests are driven and retired on done.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [1:0]  c_size = 2'b00, d_size = 2'b00;
    logic [31:0] c_addr = 32'h0, c_wdata = 32'h0, d_addr = 32'h0, d_wdata = 32'h0;
    logic        c_gnt, c_done, c_err, d_gnt, d_done, d_err;
    logic [31:0] c_rdata, d_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    always #5 clk = ~clk;

    dmem_ctrl dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_done(c_done), .c_err(c_err), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // Behavioural dmem: 64 words, combinational read, write on posedge
    logic [31:0] dmem [0:63];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = 6'd0;
    logic [31:0] pre_val = 32'h0;

    assign mem_rd = (mem_a[31:8] == 24'd0) ? dmem[mem_a[7:2]] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (pre_en) dmem[pre_idx] <= pre_val;
        else if (mem_we && mem_a[31:8] == 24'd0) dmem[mem_a[7:2]] <= mem_wd;
    end

    typedef struct {
        logic        err;
        logic        load;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t        c_q[$];
    exp_t        d_q[$];
    logic [31:0] exp_mem [0:63];

    int checks = 0, failures = 0;
    int cyc = 0, c_gcyc = 0, d_gcyc = 0;
    int we_cnt = 0, we_cyc = 0, done_cnt = 0;
    logic [31:0] we_addr = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (mem_we) begin
            we_cnt++;
            we_cyc  = cyc;
            we_addr = mem_a;
        end
        if (c_done) begin
            done_cnt++;
            if (c_q.size() == 0) check("c_spurious_done", 32'd1, 32'd0);
            else begin
                e = c_q.pop_front();
                check("c_err", {31'd0, c_err}, {31'd0, e.err});
                if (e.load && !e.err) check("c_rdata", c_rdata, e.rdata);
                check("c_latency", cyc - c_gcyc, e.lat);
                $display("txn C err=%0b rdata=0x%08h lat=%0d", c_err, c_rdata, cyc - c_gcyc);
            end
        end
        if (d_done) begin
            done_cnt++;
            if (d_q.size() == 0) check("d_spurious_done", 32'd1, 32'd0);
            else begin
                e = d_q.pop_front();
                check("d_err", {31'd0, d_err}, {31'd0, e.err});
                if (e.load && !e.err) check("d_rdata", d_rdata, e.rdata);
                check("d_latency", cyc - d_gcyc, e.lat);
                $display("txn D err=%0b rdata=0x%08h lat=%0d", d_err, d_rdata, cyc - d_gcyc);
            end
        end
        if (c_gnt) c_gcyc = cyc;
        if (d_gnt) d_gcyc = cyc;
    end

    function automatic logic model_err(input logic [1:0] sz, input logic [31:0] addr);
        return (sz == 2'b11) || (sz == 2'b01 && addr[0]) ||
               (sz == 2'b10 && addr[1:0] != 2'b00) || (addr > 32'hFF);
    endfunction

    // Byte-by-byte store into the expected image
    task automatic model_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] wd);
        int nb;
        int ba;
        nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        for (int b = 0; b < nb; b++) begin
            ba = int'(addr[7:0]) + b;
            exp_mem[ba / 4][8 * (ba % 4) +: 8] = wd[8 * b +: 8];
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] v);
        @(posedge clk); #1;
        pre_en = 1'b1; pre_idx = idx[5:0]; pre_val = v;
        @(posedge clk); #1;
        pre_en = 1'b0;
        exp_mem[idx] = v;
    endtask

    task automatic issue(input logic port, input logic we, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        int   n;
        e.err   = model_err(sz, addr);
        e.load  = !we;
        e.rdata = e.err ? 32'h0 : exp_mem[addr[7:2]];
        e.lat   = (!e.err && we && sz != 2'b10) ? 3 : 2;
        if (!e.err && we) model_store(addr, sz, wd);
        @(posedge clk); #1;
        if (port) begin
            d_q.push_back(e);
            d_we = we; d_size = sz; d_addr = addr; d_wdata = wd; d_req = 1'b1;
        end else begin
            c_q.push_back(e);
            c_we = we; c_size = sz; c_addr = addr; c_wdata = wd; c_req = 1'b1;
        end
        n = 0;
        @(negedge clk);
        while (!(port ? d_gnt : c_gnt) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!(port ? d_gnt : c_gnt)) check("gnt_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        c_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((c_q.size() != 0 || d_q.size() != 0) && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        if (c_q.size() != 0 || d_q.size() != 0) begin
            check("done_timeout", c_q.size() + d_q.size(), 32'd0);
            c_q.delete();
            d_q.delete();
        end
    endtask

    initial begin : main
        exp_t e;
        int   n, guard, w0, d0;
        logic exp_port;
        logic [31:0] a;

        for (int i = 0; i < 64; i++) preload(i, 32'h0);

        // Reset state, including a request that must not be granted during reset
        @(negedge clk);
        c_req = 1'b1;
        #1;
        check("rst_c_gnt", {31'd0, c_gnt}, 32'd0);
        check("rst_c_done", {31'd0, c_done}, 32'd0);
        check("rst_d_done", {31'd0, d_done}, 32'd0);
        check("rst_c_err", {31'd0, c_err}, 32'd0);
        check("rst_c_rdata", c_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_wd", mem_wd, 32'h0);
        c_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Continuous contention: strict C, D, C, D alternation
        preload(8, 32'hC0C0_0008);
        preload(9, 32'hD0D0_0009);
        @(posedge clk); #1;
        c_we = 1'b0; c_size = 2'b10; c_addr = 32'h20;
        d_we = 1'b0; d_size = 2'b10; d_addr = 32'h24;
        c_req = 1'b1; d_req = 1'b1;
        exp_port = 1'b0;
        n = 0; guard = 0;
        while (n < 8 && guard < 60) begin
            @(negedge clk);
            guard++;
            if (c_gnt || d_gnt) begin
                check("rr_order", {30'd0, c_gnt, d_gnt}, exp_port ? 32'h1 : 32'h2);
                e.err = 1'b0; e.load = 1'b1; e.lat = 2;
                if (c_gnt) begin
                    e.rdata = exp_mem[8];
                    c_q.push_back(e);
                end else begin
                    e.rdata = exp_mem[9];
                    d_q.push_back(e);
                end
                exp_port = ~exp_port;
                n++;
            end
        end
        if (n < 8) check("rr_count", n, 32'd8);
        @(posedge clk); #1;
        c_req = 1'b0; d_req = 1'b0;
        wait_idle();

        // Word store then load
        w0 = we_cnt;
        issue(1'b0, 1'b1, 2'b10, 32'h4, 32'hABCD_EF01);
        wait_idle();
        check("t1_we_cnt", we_cnt - w0, 32'd1);
        check("t1_we_addr", we_addr, 32'h4);
        check("t1_we_time", we_cyc - c_gcyc, 32'd1);
        issue(1'b0, 1'b0, 2'b10, 32'h4, 32'h0);
        wait_idle();
        check("t1_mem", dmem[1], 32'hABCD_EF01);

        // Byte store read-modify-write
        preload(2, 32'h1122_3344);
        w0 = we_cnt;
        issue(1'b0, 1'b1, 2'b00, 32'hA, 32'h0000_00AA);
        wait_idle();
        check("t2_we_cnt", we_cnt - w0, 32'd1);
        check("t2_we_time", we_cyc - c_gcyc, 32'd2);
        issue(1'b0, 1'b0, 2'b10, 32'h8, 32'h0);
        wait_idle();
        check("t2_mem", dmem[2], 32'h11AA_3344);

        // Upper-half store over zero
        preload(3, 32'h0);
        issue(1'b1, 1'b1, 2'b01, 32'hE, 32'h0000_BEEF);
        wait_idle();
        issue(1'b0, 1'b0, 2'b10, 32'hC, 32'h0);
        wait_idle();
        check("t6_mem", dmem[3], 32'hBEEF_0000);

        // Rejected accesses: no writes, memory untouched
        w0 = we_cnt;
        issue(1'b1, 1'b1, 2'b01, 32'h5, 32'h1234);
        wait_idle();
        issue(1'b0, 1'b0, 2'b10, 32'h2, 32'h0);
        wait_idle();
        issue(1'b1, 1'b1, 2'b10, 32'h100, 32'h5555);
        wait_idle();
        issue(1'b0, 1'b1, 2'b11, 32'h8, 32'h7777);
        wait_idle();
        check("t4_we_cnt", we_cnt - w0, 32'd0);
        check("t4_mem1", dmem[1], 32'hABCD_EF01);
        check("t4_mem2", dmem[2], 32'h11AA_3344);

        // Reset during RMW_WR drops the write and the done
        preload(4, 32'h5566_7788);
        @(posedge clk); #1;
        c_we = 1'b1; c_size = 2'b00; c_addr = 32'h11; c_wdata = 32'h99; c_req = 1'b1;
        n = 0;
        @(negedge clk);
        while (!c_gnt && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_gnt", {31'd0, c_gnt}, 32'd1);
        @(posedge clk); #1;
        c_req = 1'b0;
        @(negedge clk);
        check("t5_access_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        check("t5_rmw_we", {31'd0, mem_we}, 32'd1);
        check("t5_rmw_a", mem_a, 32'h10);
        d0 = done_cnt;
        #1 reset = 1'b1;
        #1 check("t5_rst_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_no_done", done_cnt - d0, 32'd0);
        check("t5_mem", dmem[4], 32'h5566_7788);
        @(posedge clk); #1;
        e.err = 1'b0; e.load = 1'b1; e.lat = 2; e.rdata = exp_mem[4];
        c_q.push_back(e);
        c_we = 1'b0; c_size = 2'b10; c_addr = 32'h10;
        d_we = 1'b0; d_size = 2'b10; d_addr = 32'h24;
        c_req = 1'b1; d_req = 1'b1;
        @(negedge clk);
        check("t5_c_first", {30'd0, c_gnt, d_gnt}, 32'h2);
        @(posedge clk); #1;
        c_req = 1'b0; d_req = 1'b0;
        wait_idle();

        // Mixed random traffic, sequential
        for (int i = 0; i < 24; i++) begin
            a = ($urandom_range(0, 9) == 0) ? 32'h100 + 32'($urandom_range(0, 255))
                                             : 32'($urandom_range(0, 255));
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), a, $urandom);
            wait_idle();
        end

        for (int i = 0; i < 64; i++) check($sformatf("final_mem[%0d]", i), dmem[i], exp_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
